// File: rtl/ballot_collector_if.sv
// Bundle between the ballot collector and its voters / downstream consumer.
// slave = the collector, master = whoever drives votes and accepts ballots.
interface ballot_collector_if #(
  parameter int N_VOTERS = 3
);
  localparam int YES_W = $clog2(N_VOTERS + 1);

  logic                start;
  logic [N_VOTERS-1:0] vote_valid;
  logic [N_VOTERS-1:0] vote_val;
  logic                busy;
  logic [N_VOTERS-1:0] voted;
  logic [N_VOTERS-1:0] ballot;
  logic [YES_W-1:0]    yes_cnt;
  logic                result;
  logic                timed_out;
  // Handshake: a ballot transfers in any cycle where ballot_valid and
  // ballot_ready are both high. Once raised, ballot_valid stays high and
  // ballot/voted/yes_cnt/result/timed_out stay stable until that transfer;
  // ballot_ready may be driven freely and is ignored while ballot_valid is low.
  logic                ballot_valid;
  logic                ballot_ready;

  modport master (
    output start, vote_valid, vote_val, ballot_ready,
    input  busy, voted, ballot, yes_cnt, result, ballot_valid, timed_out
  );

  modport slave (
    input  start, vote_valid, vote_val, ballot_ready,
    output busy, voted, ballot, yes_cnt, result, ballot_valid, timed_out
  );
endinterface

// File: rtl/ballot_collector.sv
// Collects first-vote-wins ballots per session and hands them to the majority consumer.
// Optional session timeout is compiled in with `define VOTE_TIMEOUT_EN.
module ballot_collector #(
  parameter int N_VOTERS    = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  ballot_collector_if.slave bus,
  output logic [1:0]        o_dbg_state
);
  localparam int YES_W = $clog2(N_VOTERS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_cnt_w_check
    $error("ballot_collector: CNT_W too narrow for TIMEOUT_CYC");
  end

  state_t              r_state;
  logic                r_busy;
  logic                r_ballot_valid;
  logic                r_timed_out;
  logic                r_result;
  logic [N_VOTERS-1:0] r_voted;
  logic [N_VOTERS-1:0] r_ballot;
  logic [YES_W-1:0]    r_yes_cnt;

  logic [N_VOTERS-1:0] w_accept;
  logic [N_VOTERS-1:0] w_voted_nxt;
  logic [N_VOTERS-1:0] w_ballot_nxt;
  logic [YES_W-1:0]    w_yes_nxt;
  logic                w_result_nxt;
  logic                w_all_voted;
  logic                w_timeout;

  // Only voters without a latched vote are accepted; unvoted ballot bits are
  // always 0, so OR-ing in the new values is enough.
  assign w_accept     = bus.vote_valid & ~r_voted;
  assign w_voted_nxt  = r_voted | w_accept;
  assign w_ballot_nxt = r_ballot | (bus.vote_val & w_accept);
  assign w_all_voted  = &w_voted_nxt;

  // Count from the post-edge ballot so yes_cnt/result are already right in
  // the first DONE cycle.
  always_comb begin
    w_yes_nxt = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      w_yes_nxt = w_yes_nxt + YES_W'(w_ballot_nxt[i]);
    end
  end

  assign w_result_nxt = (32'(w_yes_nxt) > 32'(N_VOTERS / 2));

`ifdef VOTE_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_COLLECT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_ballot_valid <= 1'b0;
      r_timed_out    <= 1'b0;
      r_result       <= 1'b0;
      r_voted        <= '0;
      r_ballot       <= '0;
      r_yes_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_COLLECT;
            r_busy      <= 1'b1;
            r_timed_out <= 1'b0;
            r_result    <= 1'b0;
            r_voted     <= '0;
            r_ballot    <= '0;
            r_yes_cnt   <= '0;
          end
        end
        S_COLLECT: begin
          r_voted   <= w_voted_nxt;
          r_ballot  <= w_ballot_nxt;
          r_yes_cnt <= w_yes_nxt;
          r_result  <= w_result_nxt;
          // A complete ballot beats a timeout landing on the same edge.
          if (w_all_voted) begin
            r_state        <= S_DONE;
            r_ballot_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state        <= S_DONE;
            r_ballot_valid <= 1'b1;
            r_timed_out    <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.ballot_ready) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_ballot_valid <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
          r_ballot_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.voted        = r_voted;
  assign bus.ballot       = r_ballot;
  assign bus.yes_cnt      = r_yes_cnt;
  assign bus.result       = r_result;
  assign bus.ballot_valid = r_ballot_valid;
  assign bus.timed_out    = r_timed_out;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector: vector table, hand-written corner
// sequences and randomized sessions checked against a first-vote-wins model.
module tb_ballot_collector;
  localparam int N = 3;
`ifdef VOTE_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1000;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int CW = $clog2(TO + 1);
  localparam int W  = 7;  // {timed_out, result, yes_cnt[1:0], ballot[2:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] exp_q[$];

  ballot_collector_if #(.N_VOTERS(N)) bus ();

  ballot_collector #(
    .N_VOTERS(N),
    .TIMEOUT_CYC(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] out_word();
    return {bus.timed_out, bus.result, bus.yes_cnt, bus.ballot};
  endfunction

  // First vote per voter wins; a session closes at the cycle its last missing
  // voter first votes, or at cycle TO-1 with whatever arrived by then.
  function automatic void model(input logic [2:0] vv[$], input logic [2:0] vl[$],
                                output int done_c, output logic [2:0] ev,
                                output logic [2:0] eb, output logic eto);
    int first_c[N];
    logic [2:0] full;
    int last;
    bit all;
    full = '0;
    last = 0;
    all  = 1'b1;
    for (int i = 0; i < N; i++) first_c[i] = -1;
    for (int c = 0; c < vv.size(); c++) begin
      for (int i = 0; i < N; i++) begin
        if (vv[c][i] && first_c[i] < 0) begin
          first_c[i] = c;
          full[i]    = vl[c][i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (first_c[i] < 0) all = 1'b0;
      else if (first_c[i] > last) last = first_c[i];
    end
    if (all && (!TO_EN || last < TO)) begin
      done_c = last;
      eto    = 1'b0;
      ev     = '1;
      eb     = full;
    end else begin
      done_c = TO - 1;
      eto    = 1'b1;
      ev     = '0;
      for (int i = 0; i < N; i++) ev[i] = (first_c[i] >= 0 && first_c[i] < TO);
      eb = full & ev;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_session(input logic [2:0] vv[$], input logic [2:0] vl[$], input int hold);
    int done_c;
    logic [2:0] ev, eb;
    logic eto, er;
    logic [1:0] ey;
    logic [W-1:0] ew;
    model(vv, vl, done_c, ev, eb, eto);
    ey = '0;
    for (int i = 0; i < N; i++) ey = ey + 2'(eb[i]);
    er = (int'(ey) * 2 > N);
    ew = {eto, er, ey, eb};
    exp_q.push_back(ew);

    // Votes in the start cycle must be ignored.
    bus.start        = 1'b1;
    bus.vote_valid   = 3'($urandom_range(0, 7));
    bus.vote_val     = 3'($urandom_range(0, 7));
    bus.ballot_ready = 1'($urandom_range(0, 1));
    step();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("voted_cleared", 32'(bus.voted), 32'd0);

    for (int c = 0; c <= done_c; c++) begin
      bus.vote_valid   = (c < vv.size()) ? vv[c] : 3'b000;
      bus.vote_val     = (c < vl.size()) ? vl[c] : 3'b000;
      bus.start        = 1'($urandom_range(0, 1));
      bus.ballot_ready = 1'($urandom_range(0, 1));
      step();
      if (c < done_c) chk("valid_early", 32'(bus.ballot_valid), 32'd0);
    end
    chk("valid_on_time", 32'(bus.ballot_valid), 32'd1);
    chk("voted_done", 32'(bus.voted), 32'(ev));
    chk("out_word_done", 32'(out_word()), 32'(ew));

    for (int h = 0; h < hold; h++) begin
      bus.vote_valid   = 3'($urandom_range(0, 7));
      bus.vote_val     = 3'($urandom_range(0, 7));
      bus.start        = 1'($urandom_range(0, 1));
      bus.ballot_ready = 1'b0;
      step();
      chk("hold_valid", 32'(bus.ballot_valid), 32'd1);
      chk("hold_word", 32'(out_word()), 32'(ew));
      chk("hold_voted", 32'(bus.voted), 32'(ev));
    end

    // Handshake cycle, with a start that must not open a new session.
    bus.ballot_ready = 1'b1;
    bus.start        = 1'b1;
    bus.vote_valid   = 3'($urandom_range(0, 7));
    bus.vote_val     = 3'($urandom_range(0, 7));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: handshake with empty expected queue");
    end else begin
      chk("scoreboard", 32'(out_word()), 32'(exp_q.pop_front()));
    end
    step();
    bus.ballot_ready = 1'b0;
    bus.start        = 1'b0;
    bus.vote_valid   = 3'b000;
    bus.vote_val     = 3'b000;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_valid", 32'(bus.ballot_valid), 32'd0);
    chk("idle_keep", 32'({bus.result, bus.yes_cnt, bus.ballot}), 32'(ew[5:0]));
    step();
    chk("start_in_hs_ignored", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              ncyc;
    logic [3:0][2:0] vv;   // entry c = cycle c of COLLECT
    logic [3:0][2:0] vl;
    logic [2:0]      e_ballot;
    logic [1:0]      e_yes;
    logic            e_result;
  } vec_t;

  function automatic vec_t mk(int n, logic [11:0] vv, logic [11:0] vl,
                              logic [2:0] b, logic [1:0] y, logic r);
    vec_t v;
    v.ncyc = n; v.vv = vv; v.vl = vl;
    v.e_ballot = b; v.e_yes = y; v.e_result = r;
    return v;
  endfunction

  // ---------------- main ----------------
  initial begin
    vec_t vecs[6];
    logic [2:0] qv[$];
    logic [2:0] ql[$];

    vecs[0] = mk(1, 12'b000_000_000_111, 12'b000_000_000_011, 3'b011, 2'd2, 1'b1);
    vecs[1] = mk(4, 12'b100_001_010_001, 12'b000_000_000_001, 3'b001, 2'd1, 1'b0);
    vecs[2] = mk(2, 12'b000_000_011_100, 12'b000_000_011_100, 3'b111, 2'd3, 1'b1);
    vecs[3] = mk(2, 12'b000_000_101_010, 12'b000_000_000_010, 3'b010, 2'd1, 1'b0);
    vecs[4] = mk(3, 12'b000_001_110_110, 12'b000_000_000_110, 3'b110, 2'd2, 1'b1);
    vecs[5] = mk(1, 12'b000_000_000_111, 12'b000_000_000_000, 3'b000, 2'd0, 1'b0);

    bus.start = 1'b0; bus.vote_valid = '0; bus.vote_val = '0; bus.ballot_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.ballot_valid), 32'd0);
    chk("rst_voted", 32'(bus.voted), 32'd0);
    chk("rst_word", 32'(out_word()), 32'd0);
    rst = 1'b0;

    // Votes only in the start cycle: nothing latched.
    bus.start = 1'b1; bus.vote_valid = 3'b111; bus.vote_val = 3'b111;
    step();
    bus.start = 1'b0; bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    chk("startcyc_voted", 32'(bus.voted), 32'd0);
    chk("startcyc_busy", 32'(bus.busy), 32'd1);
`ifdef VOTE_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      step();
      if (c < TO - 1) chk("to_valid_early", 32'(bus.ballot_valid), 32'd0);
    end
    chk("to_valid", 32'(bus.ballot_valid), 32'd1);
    chk("to_word", 32'(out_word()), 32'b100_0000);
    chk("to_voted", 32'(bus.voted), 32'd0);
    bus.ballot_ready = 1'b1;
    step();
    bus.ballot_ready = 1'b0;
    chk("to_idle_busy", 32'(bus.busy), 32'd0);
`else
    for (int c = 0; c < 12; c++) begin
      step();
      chk("wait_valid", 32'(bus.ballot_valid), 32'd0);
    end
    chk("wait_voted", 32'(bus.voted), 32'd0);
`endif

    // Reset in the middle of COLLECT discards the partial ballot.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.vote_valid = 3'b010; bus.vote_val = 3'b010;
    step();
    bus.vote_valid = 3'b000; bus.vote_val = 3'b000;
    chk("mid_voted", 32'(bus.voted), 32'b010);
    chk("mid_ballot", 32'(bus.ballot), 32'b010);
    chk("mid_yes", 32'(bus.yes_cnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_voted", 32'(bus.voted), 32'd0);
    chk("midrst_word", 32'(out_word()), 32'd0);
    chk("midrst_valid", 32'(bus.ballot_valid), 32'd0);

    for (int k = 0; k < 6; k++) begin
      qv.delete();
      ql.delete();
      for (int c = 0; c < vecs[k].ncyc; c++) begin
        qv.push_back(vecs[k].vv[c]);
        ql.push_back(vecs[k].vl[c]);
      end
      run_session(qv, ql, (k == 0) ? 5 : 2);
      chk("tbl_ballot", 32'(bus.ballot), 32'(vecs[k].e_ballot));
      chk("tbl_yes", 32'(bus.yes_cnt), 32'(vecs[k].e_yes));
      chk("tbl_result", 32'(bus.result), 32'(vecs[k].e_result));
    end

    // Final vote lands in the 8th COLLECT cycle (coincides with timeout when enabled).
    qv.delete();
    ql.delete();
    for (int c = 0; c < 8; c++) begin
      qv.push_back((c == 0) ? 3'b001 : (c == 7) ? 3'b110 : 3'b000);
      ql.push_back((c == 0) ? 3'b001 : (c == 7) ? 3'b110 : 3'b000);
    end
    run_session(qv, ql, 1);
    chk("late_ballot", 32'(bus.ballot), 32'b111);
    chk("late_yes", 32'(bus.yes_cnt), 32'd3);

    for (int s = 0; s < 40; s++) begin
      int len;
      len = $urandom_range(1, 10);
      qv.delete();
      ql.delete();
      for (int c = 0; c < len; c++) begin
        qv.push_back((c == len - 1) ? 3'b111 : 3'($urandom_range(0, 7) & $urandom_range(0, 7)));
        ql.push_back(3'($urandom_range(0, 7)));
      end
      run_session(qv, ql, $urandom_range(0, 3));
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
